// File: rtl/rnd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : rnd_arbiter
// Purpose  : Round-robin scheduler that shares one 5-bit Fibonacci LFSR among
//            N_REQ requesters. Each granted draw advances the LFSR SHIFTS
//            times, then returns the value to the winner with a one-cycle
//            grant pulse.
// Ports    : clk       - rising-edge clock
//            rst       - asynchronous active-high reset
//            req       - per-requester level request, held until granted
//            gnt       - one-hot grant pulse (one cycle)
//            rnd_valid - high exactly when gnt is nonzero
//            rnd       - drawn value, held between draws
//            seed_we   - seed load strobe (honoured only when idle)
//            seed      - seed value (zero is rejected)
//            seed_err  - one-cycle pulse when a seed load is rejected
//            busy      - high whenever a draw is in progress
// Revision : 1.0 - initial release
// ============================================================================
module rnd_arbiter #(
  parameter int         N_REQ      = 4,
  parameter int         SHIFTS     = 5,
  parameter logic [4:0] RESET_SEED = 5'b11100
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [N_REQ-1:0] req,
  output logic [N_REQ-1:0] gnt,
  output logic             rnd_valid,
  output logic [4:0]       rnd,
  input  logic             seed_we,
  input  logic [4:0]       seed,
  output logic             seed_err,
  output logic             busy
);

  localparam int               c_PW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam logic [4:0]       c_SHIFTS = 5'(SHIFTS);
  localparam logic [c_PW:0]    c_N      = (c_PW + 1)'(N_REQ);
  localparam logic [c_PW-1:0]  c_LAST   = c_PW'(N_REQ - 1);
  localparam logic [N_REQ-1:0] c_ONE    = {{(N_REQ-1){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    SHIFT   = 2'd1,
    DELIVER = 2'd2
  } state_t;

  state_t            r_state, w_state_nxt;
  logic [4:0]        r_q, w_q_nxt, w_q_step;
  logic [4:0]        r_cnt, w_cnt_nxt;
  logic [4:0]        r_rnd, w_rnd_nxt;
  logic [c_PW-1:0]   r_win, w_win_nxt;
  logic [c_PW-1:0]   r_ptr, w_ptr_nxt;
  logic [c_PW-1:0]   w_pick;
  logic              w_pick_vld;
  logic [N_REQ-1:0]  r_gnt, w_gnt_nxt;
  logic              r_valid, w_valid_nxt;
  logic              r_err, w_err_nxt;

  // One LFSR step; taps keep the 31 nonzero states in a single cycle.
  assign w_q_step = {r_q[3:0], r_q[4] ^ r_q[2]};

  // Rotating-priority scan: first set request at or after the pointer,
  // wrapping past the top requester back to zero.
  always_comb begin
    logic [c_PW:0]   sum;
    logic [c_PW-1:0] idx;
    sum        = '0;
    idx        = '0;
    w_pick     = '0;
    w_pick_vld = 1'b0;
    for (int i = 0; i < N_REQ; i++) begin
      sum = {1'b0, r_ptr} + (c_PW + 1)'(i);
      if (sum >= c_N) begin
        sum = sum - c_N;
      end
      idx = sum[c_PW-1:0];
      if (!w_pick_vld && req[idx]) begin
        w_pick     = idx;
        w_pick_vld = 1'b1;
      end
    end
  end

  // Next-state and next-output logic. All outputs are taken from registers,
  // so nothing here reaches a port combinationally.
  always_comb begin
    w_state_nxt = r_state;
    w_q_nxt     = r_q;
    w_cnt_nxt   = r_cnt;
    w_win_nxt   = r_win;
    w_ptr_nxt   = r_ptr;
    w_rnd_nxt   = r_rnd;
    w_gnt_nxt   = '0;
    w_valid_nxt = 1'b0;
    w_err_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        // A seed strobe owns the cycle; arbitration waits one cycle.
        if (seed_we) begin
          if (seed != 5'd0) begin
            w_q_nxt = seed;
          end else begin
            w_err_nxt = 1'b1;
          end
        end else if (w_pick_vld) begin
          w_win_nxt   = w_pick;
          w_cnt_nxt   = c_SHIFTS;
          w_state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        w_err_nxt = seed_we;
        w_q_nxt   = w_q_step;
        w_cnt_nxt = r_cnt - 5'd1;
        if (r_cnt == 5'd1) begin
          // Winner's request is only looked at on the final step; a dropped
          // request aborts without moving the pointer, steps already taken.
          if (req[r_win]) begin
            w_state_nxt = DELIVER;
            w_gnt_nxt   = c_ONE << r_win;
            w_valid_nxt = 1'b1;
            w_rnd_nxt   = w_q_step;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      DELIVER: begin
        w_err_nxt   = seed_we;
        w_ptr_nxt   = (r_win == c_LAST) ? '0 : r_win + c_PW'(1);
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= IDLE;
      r_q     <= RESET_SEED;
      r_cnt   <= '0;
      r_win   <= '0;
      r_ptr   <= '0;
      r_rnd   <= '0;
      r_gnt   <= '0;
      r_valid <= 1'b0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_q     <= w_q_nxt;
      r_cnt   <= w_cnt_nxt;
      r_win   <= w_win_nxt;
      r_ptr   <= w_ptr_nxt;
      r_rnd   <= w_rnd_nxt;
      r_gnt   <= w_gnt_nxt;
      r_valid <= w_valid_nxt;
      r_err   <= w_err_nxt;
    end
  end

  assign gnt       = r_gnt;
  assign rnd_valid = r_valid;
  assign rnd       = r_rnd;
  assign seed_err  = r_err;
  assign busy      = (r_state != IDLE);

endmodule
`default_nettype wire

// File: tb/tb_rnd_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_rnd_arbiter
// Purpose  : Self-checking bench for rnd_arbiter. A transaction-level model
//            (LFSR as integer arithmetic, round robin as a modular scan)
//            predicts winner, latency and value of every draw.
// Ports    : none
// Revision : 1.0 - initial release
// ============================================================================
module tb_rnd_arbiter;

  localparam int N  = 4;
  localparam int SH = 5;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req, gnt;
  logic       rnd_valid, seed_we, seed_err, busy;
  logic [4:0] rnd, seed;
  logic [3:0] req1, gnt1;
  logic       rnd_valid1, seed_we1, seed_err1, busy1;
  logic [4:0] rnd1, seed1;

  int n_checks = 0;
  int n_pass   = 0;
  int m_q;
  int m_ptr;

  always #5 clk = ~clk;

  rnd_arbiter #(.N_REQ(N), .SHIFTS(SH), .RESET_SEED(5'b11100)) dut (
    .clk(clk), .rst(rst), .req(req), .gnt(gnt), .rnd_valid(rnd_valid),
    .rnd(rnd), .seed_we(seed_we), .seed(seed), .seed_err(seed_err),
    .busy(busy)
  );

  rnd_arbiter #(.N_REQ(N), .SHIFTS(1), .RESET_SEED(5'b11100)) dut_p (
    .clk(clk), .rst(rst), .req(req1), .gnt(gnt1), .rnd_valid(rnd_valid1),
    .rnd(rnd1), .seed_we(seed_we1), .seed(seed1), .seed_err(seed_err1),
    .busy(busy1)
  );

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
  endtask

  // LFSR step: shift left, feed bit4 xor bit2 into bit0.
  function automatic int lfsr(input int q);
    return ((q * 2) % 32) + (((q / 16) + (q / 4)) % 2);
  endfunction

  function automatic int pick(input int r, input int ptr);
    for (int i = 0; i < N; i++) begin
      int idx;
      idx = (ptr + i) % N;
      if (((r >> idx) & 1) == 1) return idx;
    end
    return -1;
  endfunction

  // Entered during an IDLE cycle with req already set. mode 0: normal draw,
  // 1: winner drops its request mid-draw (abort), 2: seed strobe while busy.
  task automatic serve(input int mode, input bit clr);
    int w, e, lat, lim;
    w = pick(int'(req), m_ptr);
    e = m_q;
    for (int s = 0; s < SH; s++) e = lfsr(e);
    lat = 0;
    lim = (mode == 1) ? SH + 1 : SH + 4;
    for (int c = 1; c <= lim && lat == 0; c++) begin
      @(posedge clk); #1;
      if (c == 1) check("busy_rise", int'(busy), 1);
      if (c == 2 && mode == 1) req[w] = 1'b0;
      if (c == 2 && mode == 2) begin
        seed_we = 1'b1;
        seed    = 5'($urandom_range(1, 31));
      end
      if (c == 3 && mode == 2) begin
        check("seed_err_busy", int'(seed_err), 1);
        seed_we = 1'b0;
      end
      if (gnt != 4'd0) lat = c;
      if (mode == 1 && c == SH + 1) check("abort_idle", int'(busy), 0);
    end
    m_q = e;
    if (mode == 1) begin
      check("abort_no_gnt", lat, 0);
    end else begin
      check("latency", lat, SH + 1);
      check("gnt", int'(gnt), 1 << w);
      check("rnd", int'(rnd), e);
      check("rnd_valid", int'(rnd_valid), 1);
      m_ptr = (w + 1) % N;
      if (clr) req[w] = 1'b0;
      @(posedge clk); #1;
      check("idle_after", int'(busy), 0);
    end
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int vals[32];
    int seen[32];
    int distinct, got, sv;

    rst = 1'b1; req = '0; seed_we = 1'b0; seed = '0;
    req1 = '0; seed_we1 = 1'b0; seed1 = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", int'(gnt), 0);
    check("rst_valid", int'(rnd_valid), 0);
    check("rst_rnd", int'(rnd), 0);
    check("rst_err", int'(seed_err), 0);
    check("rst_busy", int'(busy), 0);
    rst = 1'b0;
    m_q = 28; m_ptr = 0;

    // Single draws by requester 0.
    req = 4'b0001; serve(0, 1'b1);
    check("first_draw", int'(rnd), 5'b01101);
    req = 4'b0001; serve(0, 1'b1);
    check("second_draw", int'(rnd), 5'b11010);

    // Round robin with all requesting, then requester 2 drops out.
    req = 4'b1111;
    repeat (3) serve(0, 1'b0);
    req[2] = 1'b0;
    repeat (4) serve(0, 1'b0);
    req = '0;

    // Seed load takes priority over a simultaneous request.
    seed_we = 1'b1; seed = 5'b00001; req = 4'b0001;
    @(posedge clk); #1;
    seed_we = 1'b0;
    check("seed_ok_err", int'(seed_err), 0);
    check("seed_skip_arb", int'(busy), 0);
    m_q = 1;
    serve(0, 1'b1);
    check("seeded_draw", int'(rnd), 5'b00101);

    // Zero seed rejected.
    seed_we = 1'b1; seed = 5'd0;
    @(posedge clk); #1;
    seed_we = 1'b0;
    check("zero_seed_err", int'(seed_err), 1);
    @(posedge clk); #1;
    check("zero_seed_pulse", int'(seed_err), 0);
    req = 4'b0010; serve(0, 1'b1);

    // Seed strobe while busy is rejected and has no effect.
    req = 4'b0100; serve(2, 1'b1);

    // Abort, then a full draw confirms pointer and LFSR progression.
    req = 4'b0010; serve(1, 1'b0);
    req = 4'b1111; serve(0, 1'b0);
    req = '0;
    @(posedge clk); #1;

    // Reset in the third SHIFT cycle.
    req = 4'b0001;
    repeat (3) begin @(posedge clk); #1; end
    check("pre_rst_busy", int'(busy), 1);
    rst = 1'b1;
    #1;
    check("mid_rst_busy", int'(busy), 0);
    check("mid_rst_gnt", int'(gnt), 0);
    check("mid_rst_rnd", int'(rnd), 0);
    check("mid_rst_valid", int'(rnd_valid), 0);
    @(posedge clk); #1;
    rst = 1'b0;
    m_q = 28; m_ptr = 0;
    serve(0, 1'b1);
    check("post_rst_draw", int'(rnd), 5'b01101);

    // Randomized draws and seed writes.
    for (int it = 0; it < 40; it++) begin
      if ($urandom_range(0, 3) == 0) begin
        req = '0;
        sv = int'($urandom_range(0, 31));
        seed_we = 1'b1; seed = 5'(sv);
        @(posedge clk); #1;
        seed_we = 1'b0;
        check("rand_seed_err", int'(seed_err), (sv == 0) ? 1 : 0);
        if (sv != 0) m_q = sv;
      end else begin
        req = 4'($urandom_range(1, 15));
        serve(($urandom_range(0, 4) == 0) ? 2 : 0, 1'($urandom_range(0, 1)));
      end
    end
    req = '0;

    // Period of the shared source with one step per draw.
    m_q = 28;
    req1 = 4'b0001;
    for (int k = 0; k < 32; k++) begin
      got = 0;
      for (int c = 0; c < 10 && got == 0; c++) begin
        @(posedge clk); #1;
        if (gnt1 != 4'd0) got = 1;
      end
      check("period_gnt", got, 1);
      m_q = lfsr(m_q);
      vals[k] = int'(rnd1);
      check("period_val", vals[k], m_q);
    end
    req1 = '0;
    for (int i = 0; i < 32; i++) seen[i] = 0;
    for (int k = 0; k < 31; k++) seen[vals[k]] = 1;
    distinct = 0;
    for (int i = 1; i < 32; i++) distinct += seen[i];
    check("period_distinct", distinct, 31);
    check("period_wrap", vals[31], vals[0]);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
